// File: rtl/uart_rx_word_fifo.sv
// Packs received UART bytes little-endian into 32-bit words and queues them in a show-ahead FIFO.
// A framing error drops the partial word. An overflow drops the completed word and sets a sticky flag.
module uart_rx_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               rdata,
  input  logic                     rdata_ready,
  input  logic                     ferr,
  input  logic                     clear,
  output logic [31:0]              word,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {B0, B1, B2, B3} idx_t;

  idx_t            idx;
  logic [2:0][7:0] asm_q;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            accept, complete, pop, wr_en;
  logic [AW:0]     count_nxt;

  assign accept   = rdata_ready & ~ferr & ~clear;
  assign complete = accept & (idx == B3);
  assign pop      = word_valid & word_ready & ~clear;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign wr_en    = complete & ((count != FULL) | pop);
  assign word     = mem[rd_ptr];

  always_comb begin
    count_nxt = count + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx        <= B0;
      asm_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      idx        <= B0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (ferr) begin
        idx <= B0;
      end else if (accept) begin
        case (idx)
          B0:      asm_q[0] <= rdata;
          B1:      asm_q[1] <= rdata;
          B2:      asm_q[2] <= rdata;
          default: ;
        endcase
        idx <= idx_t'(idx + 2'd1);
      end
      if (complete && !wr_en) overflow <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nxt;
      word_valid <= (count_nxt != '0);
    end
  end

  // Storage is intentionally left unreset; word is meaningless while word_valid is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {rdata, asm_q[2], asm_q[1], asm_q[0]};
  end

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Bench for uart_rx_word_fifo: table of byte sequences plus hand-written full/clear/reset sequences.
// Expected words are queued when their 4th byte is driven and compared when popped.
module tb_uart_rx_word_fifo;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rdata = '0;
  logic        rdata_ready = 1'b0;
  logic        ferr = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic        overflow;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];
  int          mcount = 0;

  uart_rx_word_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .rdata(rdata), .rdata_ready(rdata_ready),
    .ferr(ferr), .clear(clear), .word(word), .word_valid(word_valid),
    .word_ready(word_ready), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:3][7:0] seq;   // seq[0] is strobed first
    int              mode;  // 0 clean, 1 ferr alone after 2 junk, 2 ferr+strobe after 3 junk, 3 ferr+strobe after 1 junk
    logic [31:0]     exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rdata = b;
    rdata_ready = 1'b1;
    tick();
    rdata_ready = 1'b0;
  endtask

  // Sends four bytes; on the last one optionally pops in the same cycle, mirroring that in the model.
  task automatic send_word(input logic [0:3][7:0] s, input logic [31:0] exp, input bit pop_last);
    for (int i = 0; i < 3; i++) send_byte(s[i]);
    word_ready = pop_last;
    rdata = s[3];
    rdata_ready = 1'b1;
    if (pop_last && mcount > 0) begin
      void'(exp_q.pop_front());
      mcount--;
    end else if (pop_last) begin
      chk("pop_on_empty_model", 32'(mcount), 32'd1);
    end
    if (mcount < DEPTH) begin
      exp_q.push_back(exp);
      mcount++;
    end
    tick();
    rdata_ready = 1'b0;
    word_ready = 1'b0;
  endtask

  task automatic pop_check(input string name);
    if (exp_q.size() == 0) begin
      chk({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_valid"}, 32'(word_valid), 32'd1);
      chk(name, word, exp_q.pop_front());
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      mcount--;
    end
  endtask

  task automatic do_clear(input bit with_byte);
    clear = 1'b1;
    rdata = 8'hEE;
    rdata_ready = with_byte;
    word_ready = 1'b1;
    tick();
    clear = 1'b0;
    rdata_ready = 1'b0;
    word_ready = 1'b0;
    exp_q.delete();
    mcount = 0;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{seq: {8'h11, 8'h22, 8'h33, 8'h44}, mode: 0, exp: 32'h44332211};
    tbl[1] = '{seq: {8'h01, 8'h02, 8'h03, 8'h04}, mode: 1, exp: 32'h04030201};
    tbl[2] = '{seq: {8'hDE, 8'hAD, 8'hBE, 8'hEF}, mode: 2, exp: 32'hEFBEADDE};
    tbl[3] = '{seq: {8'h80, 8'h00, 8'hFF, 8'h7F}, mode: 3, exp: 32'h7FFF0080};
    tbl[4] = '{seq: {8'hC3, 8'h3C, 8'h5A, 8'hA5}, mode: 0, exp: 32'hA55A3CC3};

    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    #10 rstn = 1'b1;
    tick();

    // Table: each vector optionally preceded by a partial word killed by ferr.
    for (int v = 0; v < 5; v++) begin
      case (tbl[v].mode)
        1: begin
          send_byte(8'hAA); send_byte(8'hBB);
          ferr = 1'b1; tick(); ferr = 1'b0;
        end
        2: begin
          send_byte(8'h91); send_byte(8'h92); send_byte(8'h93);
          ferr = 1'b1; rdata = 8'h5A; rdata_ready = 1'b1; tick();
          ferr = 1'b0; rdata_ready = 1'b0;
        end
        3: begin
          send_byte(8'h61);
          ferr = 1'b1; rdata = 8'h62; rdata_ready = 1'b1; tick();
          ferr = 1'b0; rdata_ready = 1'b0;
        end
        default: ;
      endcase
      send_word(tbl[v].seq, tbl[v].exp, 1'b0);
      chk($sformatf("vec%0d_count", v), 32'(count), 32'd1);
      pop_check($sformatf("vec%0d_word", v));
      chk($sformatf("vec%0d_overflow", v), 32'(overflow), 32'd0);
      chk($sformatf("vec%0d_empty", v), 32'(word_valid), 32'd0);
    end

    // Overflow: five words into a four-deep FIFO with no consumer.
    for (int w = 0; w < 5; w++)
      send_word({8'(w+1), 8'h10, 8'h20, 8'h30}, {8'h30, 8'h20, 8'h10, 8'(w+1)}, 1'b0);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", word, 32'h30201001);
    for (int w = 0; w < 4; w++) pop_check($sformatf("ovf_pop%0d", w));
    chk("ovf_drained", 32'(word_valid), 32'd0);
    chk("ovf_drained_count", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    word_ready = 1'b1; tick(); word_ready = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);
    do_clear(1'b0);
    chk("clr_overflow", 32'(overflow), 32'd0);

    // Full FIFO and completing byte coincide with a pop.
    for (int w = 0; w < 4; w++)
      send_word({8'hA0 + 8'(w), 8'h01, 8'h02, 8'h03}, {8'h03, 8'h02, 8'h01, 8'hA0 + 8'(w)}, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    send_word({8'hB5, 8'h01, 8'h02, 8'h03}, 32'h030201B5, 1'b1);
    chk("fullpop_count", 32'(count), 32'd4);
    chk("fullpop_overflow", 32'(overflow), 32'd0);
    for (int w = 0; w < 4; w++) pop_check($sformatf("fullpop_pop%0d", w));
    chk("fullpop_empty", 32'(word_valid), 32'd0);

    // Clear with two words stored, three bytes pending and a coincident byte.
    send_word({8'h01, 8'h01, 8'h01, 8'h01}, 32'h01010101, 1'b0);
    send_word({8'h02, 8'h02, 8'h02, 8'h02}, 32'h02020202, 1'b0);
    send_byte(8'h71); send_byte(8'h72); send_byte(8'h73);
    do_clear(1'b1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_valid", 32'(word_valid), 32'd0);
    chk("clr_overflow2", 32'(overflow), 32'd0);
    send_word({8'h12, 8'h34, 8'h56, 8'h78}, 32'h78563412, 1'b0);
    chk("clr_fresh_count", 32'(count), 32'd1);
    pop_check("clr_fresh_word");

    // Asynchronous reset mid-word with three words stored.
    for (int w = 0; w < 3; w++)
      send_word({8'h40 + 8'(w), 8'h41, 8'h42, 8'h43}, {8'h43, 8'h42, 8'h41, 8'h40 + 8'(w)}, 1'b0);
    send_byte(8'h99); send_byte(8'h98);
    #2 rstn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(word_valid), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    mcount = 0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    send_word({8'hCA, 8'hFE, 8'hBA, 8'hBE}, 32'hBEBAFECA, 1'b0);
    chk("arst_fresh_count", 32'(count), 32'd1);
    pop_check("arst_fresh_word");
    chk("arst_fresh_empty", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/uart_rx_word_fifo.md
UART_RX_WORD_FIFO -- requirements
Module: uart_rx_word_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 32-bit word entries; power of two, 2..16.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have rdata  input  8  received byte from the UART receiver.
REQ-005 SHALL have rdata_ready  input  1  one-cycle strobe marking rdata as a new byte.
REQ-006 SHALL have ferr  input  1  receiver framing error: discard the partial word.
REQ-007 SHALL have clear  input  1  synchronous flush of the assembler, FIFO and overflow flag.
REQ-008 SHALL have word  output  32  head FIFO entry; valid only while word_valid=1.
REQ-009 SHALL have word_valid  output  1  FIFO non-empty.
REQ-010 SHALL have word_ready  input  1  consumer accept; a pop occurs when word_valid&word_ready.
REQ-011 SHALL have count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-012 SHALL have overflow  output  1  sticky: a completed word was dropped.

Function
REQ-013 SHALL assemble bytes little-endian: 1st byte to word[7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24].
REQ-014 SHALL track a 2-bit byte index (states B0..B3); each accepted byte advances it, and B3 wraps to B0 on the 4th byte.
REQ-015 SHALL accept a byte only on a cycle with rdata_ready=1, ferr=0 and clear=0.
REQ-016 SHALL handle ferr=1 (with or without rdata_ready) by resetting the index to B0 and discarding the partial word and any coincident byte; the FIFO is unaffected.
REQ-017 SHALL, when the 4th byte is accepted at edge N, write the assembled word into the FIFO at edge N, so that word_valid=1 and word is presented after edge N (zero extra latency beyond the byte strobe).
REQ-018 SHALL accept the write if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
REQ-019 SHALL, when a write is rejected, drop the word, set overflow=1 (sticky until clear or reset) and reset the index to B0.
REQ-020 SHALL present word combinationally from the registered head entry (show-ahead); word SHALL hold stable while word_valid=1 and no pop occurs.
REQ-021 SHALL update count: +1 on a write alone, -1 on a pop alone, unchanged on simultaneous write and pop.
REQ-022 SHALL ignore word_ready while count==0; count SHALL never underflow or exceed DEPTH.
REQ-023 SHALL use read and write pointers that wrap modulo DEPTH.
REQ-024 SHALL give clear=1 priority over all other inputs: next cycle count=0, word_valid=0, overflow=0, index=B0, any coincident byte and pop discarded.
REQ-025 SHALL keep all output registers glitch-free; count, word_valid and overflow SHALL be registered or derived only from registered state.

Reset
REQ-026 SHALL, on rstn=0, immediately (asynchronously) set index=B0, pointers=0, count=0, word_valid=0, overflow=0 and assembler bytes=0.
REQ-027 SHALL leave FIFO storage contents unreset; word SHALL be don't-care while word_valid=0.
REQ-028 SHALL discard a partial word or pending FIFO data when reset is asserted mid-operation, and restart from B0 after rstn deasserts.
REQ-029 SHALL ignore rdata_ready on the first rising edge after rstn deasserts only if it coincides with deassertion; from the next edge on, bytes are accepted.

Verification
REQ-030 SHALL cover: bytes 0x11,0x22,0x33,0x44 strobed -> word=0x44332211, word_valid=1 after the 4th strobe edge, count=1.
REQ-031 SHALL cover: 0xAA,0xBB, then ferr pulse, then 0x01,0x02,0x03,0x04 -> single word 0x04030201, overflow=0.
REQ-032 SHALL cover: DEPTH=4, word_ready=0, 5 words sent -> count=4, overflow=1, head still the 1st word; pop all -> words 1..4 in order, 5th absent.
REQ-033 SHALL cover: FIFO full and 4th byte on the same cycle as a pop -> write accepted, count stays 4, overflow=0.
REQ-034 SHALL cover: 2 words stored plus 3 bytes pending, clear=1 -> count=0, word_valid=0, overflow=0; the next 4 bytes form a fresh word.
REQ-035 SHALL cover: rstn pulsed low mid-word with 3 words stored -> outputs reset asynchronously, and the subsequent 4 bytes yield exactly one correct word.
